usb_packet_decoder: RTL and testbench

Consumes the byte stream from the USB receiver's RX FIFO and reassembles it into packets: PID check, type classification, token field extraction, payload streaming and CRC5/CRC16 checking. Sits directly downstream of the receiver, drives its r_enable, and samples its rcving and r_error status. Feeds the endpoint/protocol controller with packet-level strobes.

---
 rtl/usb_pkg.sv | 51 +++++
 rtl/usb_crc_byte.sv | 40 ++++
 rtl/usb_packet_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_usb_packet_decoder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB packet decoder: PID codes, packet/error
// enums, FSM states and CRC constants.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  typedef enum logic [1:0] {
    PT_TOKEN   = 2'd0,
    PT_DATA    = 2'd1,
    PT_HSHAKE  = 2'd2,
    PT_INVALID = 2'd3
  } pkt_type_e;

  typedef enum logic [2:0] {
    PE_OK  = 3'd0,
    PE_PID = 3'd1,
    PE_CRC = 3'd2,
    PE_LEN = 3'd3,
    PE_RX  = 3'd4
  } pkt_err_e;

  typedef enum logic [3:0] {
    ST_IDLE, ST_PID, ST_TOK1, ST_TOK2, ST_TOKEND,
    ST_DATA, ST_HSEND, ST_DRAIN, ST_DONE
  } state_e;

  localparam logic [4:0]  CRC5_POLY   = 5'h05;
  localparam logic [4:0]  CRC5_INIT   = 5'h1F;
  localparam logic [4:0]  CRC5_RESID  = 5'h0C;
  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESID = 16'h800D;

  function automatic pkt_type_e pid_class(input logic [3:0] p);
    case (p)
      PID_OUT, PID_IN, PID_SETUP, PID_SOF: return PT_TOKEN;
      PID_DATA0, PID_DATA1:                return PT_DATA;
      PID_ACK, PID_NAK, PID_STALL:         return PT_HSHAKE;
      default:                             return PT_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/usb_crc_byte.sv
// Byte-wide LSB-first CRC engine shared by the token (CRC5) and data (CRC16)
// paths; crc_sel_i=1 selects CRC16.
module usb_crc_byte
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        crc_sel_i,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d, c16;
  logic [4:0]  c5;

  always_comb begin
    c16 = crc_q;
    c5  = crc_q[4:0];
    for (int i = 0; i < 8; i++) begin
      c16 = {c16[14:0], 1'b0} ^ ((c16[15] ^ data_i[i]) ? CRC16_POLY : 16'h0000);
      c5  = {c5[3:0], 1'b0} ^ ((c5[4] ^ data_i[i]) ? CRC5_POLY : 5'h00);
    end
    crc_d = crc_q;
    // CRC5 init equals the low 5 bits of the CRC16 init, so one preset serves both.
    if (init_i)
      crc_d = CRC16_INIT;
    else if (en_i)
      crc_d = crc_sel_i ? c16 : {crc_q[15:5], c5};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= CRC16_INIT;
    else     crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/usb_packet_decoder.sv
// Reassembles RX FIFO bytes into USB packets: PID check, classification,
// token field extraction, payload streaming through a 2-byte CRC hold buffer.
module usb_packet_decoder
  import usb_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64,
  parameter int CNT_W       = $clog2(MAX_PAYLOAD + 3)
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] r_data,
  input  logic       empty,
  input  logic       rcving,
  input  logic       r_error,
  output logic       r_enable,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       pkt_done,
  output logic [1:0] pkt_type,
  output logic [3:0] pid,
  output logic [6:0] addr,
  output logic [3:0] endp,
  output logic [2:0] pkt_err
);

  state_e           state_q, state_d;
  pkt_type_e        type_q, type_d;
  pkt_err_e         err_q, err_d;
  logic [3:0]       pid_q, pid_d, endp_q, endp_d;
  logic [6:0]       addr_q, addr_d;
  logic [7:0]       hold0_q, hold0_d, hold1_q, hold1_d, dout_q, dout_d;
  logic [1:0]       held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dvld_q, dvld_d;
  logic             eopk, pid_ok, crc_init, crc_en, crc_sel;
  logic [15:0]      crc;

  assign eopk    = ~rcving & empty;
  assign pid_ok  = (r_data[7:4] == ~r_data[3:0]);
  assign crc_sel = (state_q == ST_DATA);

  usb_crc_byte u_crc (
    .clk       (clk),
    .rst       (rst),
    .crc_sel_i (crc_sel),
    .init_i    (crc_init),
    .en_i      (crc_en),
    .data_i    (r_data),
    .crc_o     (crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      type_q  <= PT_TOKEN;
      err_q   <= PE_OK;
      pid_q   <= '0;
      endp_q  <= '0;
      addr_q  <= '0;
      hold0_q <= '0;
      hold1_q <= '0;
      dout_q  <= '0;
      held_q  <= '0;
      cnt_q   <= '0;
      dvld_q  <= 1'b0;
    end else begin
      type_q  <= type_d;
      err_q   <= err_d;
      pid_q   <= pid_d;
      endp_q  <= endp_d;
      addr_q  <= addr_d;
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
      dout_q  <= dout_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
      dvld_q  <= dvld_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    err_d    = err_q;
    pid_d    = pid_q;
    endp_d   = endp_q;
    addr_d   = addr_q;
    hold0_d  = hold0_q;
    hold1_d  = hold1_q;
    dout_d   = dout_q;
    held_d   = held_q;
    cnt_d    = cnt_q;
    dvld_d   = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    case (state_q)
      ST_IDLE: if (!empty) state_d = ST_PID;
      ST_PID: if (!empty) begin
        crc_init = 1'b1;
        held_d   = '0;
        cnt_d    = '0;
        err_d    = PE_OK;
        if (!pid_ok) begin
          type_d  = PT_INVALID;
          err_d   = PE_PID;
          state_d = ST_DRAIN;
        end else begin
          pid_d  = r_data[3:0];
          addr_d = '0;
          endp_d = '0;
          type_d = pid_class(r_data[3:0]);
          case (pid_class(r_data[3:0]))
            PT_TOKEN:  state_d = ST_TOK1;
            PT_DATA:   state_d = ST_DATA;
            PT_HSHAKE: state_d = ST_HSEND;
            default: begin
              err_d   = PE_PID;
              state_d = ST_DRAIN;
            end
          endcase
        end
      end
      ST_TOK1: if (!empty) begin
        crc_en    = 1'b1;
        addr_d    = r_data[6:0];
        endp_d[0] = r_data[7];
        state_d   = ST_TOK2;
      end else if (eopk) begin
        err_d   = PE_LEN;
        state_d = ST_DONE;
      end
      ST_TOK2: if (!empty) begin
        crc_en      = 1'b1;
        endp_d[3:1] = r_data[2:0];
        state_d     = ST_TOKEND;
      end else if (eopk) begin
        err_d   = PE_LEN;
        state_d = ST_DONE;
      end
      ST_TOKEND: if (!empty) begin
        err_d   = PE_LEN;
        state_d = ST_DRAIN;
      end else if (eopk) begin
        err_d   = (crc[4:0] == CRC5_RESID) ? PE_OK : PE_CRC;
        state_d = ST_DONE;
      end
      ST_HSEND: if (!empty) begin
        err_d   = PE_LEN;
        state_d = ST_DRAIN;
      end else if (eopk) begin
        state_d = ST_DONE;
      end
      // The last two bytes held at EOPK are the CRC, so payload lags the FIFO by two.
      ST_DATA: if (!empty) begin
        crc_en = 1'b1;
        if (held_q == 2'd2) begin
          if (cnt_q == CNT_W'(MAX_PAYLOAD)) begin
            err_d   = PE_LEN;
            state_d = ST_DRAIN;
          end else begin
            dout_d  = hold0_q;
            dvld_d  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            hold0_d = hold1_q;
            hold1_d = r_data;
          end
        end else if (held_q == 2'd1) begin
          hold1_d = r_data;
          held_d  = 2'd2;
        end else begin
          hold0_d = r_data;
          held_d  = 2'd1;
        end
      end else if (eopk) begin
        if (held_q != 2'd2)           err_d = PE_LEN;
        else if (crc != CRC16_RESID)  err_d = PE_CRC;
        else                          err_d = PE_OK;
        state_d = ST_DONE;
      end
      ST_DRAIN: if (empty && eopk) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (r_error && (state_q inside {ST_PID, ST_TOK1, ST_TOK2, ST_TOKEND, ST_DATA, ST_HSEND})) begin
      if (err_d == PE_OK) err_d = PE_RX;
      dvld_d  = 1'b0;
      state_d = ST_DRAIN;
    end
  end

  always_comb begin
    r_enable = 1'b0;
    pkt_done = 1'b0;
    case (state_q)
      ST_PID, ST_TOK1, ST_TOK2, ST_DATA, ST_DRAIN: r_enable = ~empty;
      ST_DONE: pkt_done = 1'b1;
      default: ;
    endcase
  end

  assign data_out   = dout_q;
  assign data_valid = dvld_q;
  assign pkt_type   = type_q;
  assign pid        = pid_q;
  assign addr       = addr_q;
  assign endp       = endp_q;
  assign pkt_err    = err_q;

endmodule

// File: tb/tb_usb_packet_decoder.sv
// Scoreboard bench for usb_packet_decoder with a first-word fall-through FIFO model.
module tb_usb_packet_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       empty = 1'b1;
  logic       rcving = 1'b0;
  logic       r_error = 1'b0;
  logic       r_enable, data_valid, pkt_done;
  logic [7:0] data_out;
  logic [1:0] pkt_type;
  logic [3:0] pid, endp;
  logic [6:0] addr;
  logic [2:0] pkt_err;

  usb_packet_decoder #(.MAX_PAYLOAD(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .r_data     (r_data),
    .empty      (empty),
    .rcving     (rcving),
    .r_error    (r_error),
    .r_enable   (r_enable),
    .data_out   (data_out),
    .data_valid (data_valid),
    .pkt_done   (pkt_done),
    .pkt_type   (pkt_type),
    .pid        (pid),
    .addr       (addr),
    .endp       (endp),
    .pkt_err    (pkt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] t;
    logic [3:0] p;
    logic [6:0] a;
    logic [3:0] e;
    logic [2:0] err;
    bit         tp;
    bit         ae;
  } exp_pkt_t;

  logic [7:0] fifo[$];
  logic [7:0] pl[$];
  logic [7:0] exp_data[$];
  exp_pkt_t   exp_pkt[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         ren_cnt = 0;
  int         ren_bad = 0;
  logic       pop_pend = 1'b0;

  always @(posedge clk) begin
    pop_pend <= r_enable;
    if (r_enable) ren_cnt <= ren_cnt + 1;
    if (r_enable && empty) ren_bad <= ren_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    empty  = (fifo.size() == 0);
    r_data = empty ? 8'h00 : fifo[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    refresh();
  endtask

  task automatic expect_pkt(input logic [1:0] t, input logic [3:0] p, input logic [6:0] a,
                            input logic [3:0] e, input logic [2:0] err, input bit tp, input bit ae);
    exp_pkt_t x;
    x.t = t; x.p = p; x.a = a; x.e = e; x.err = err; x.tp = tp; x.ae = ae;
    exp_pkt.push_back(x);
  endtask

  task automatic tick();
    exp_pkt_t x;
    @(negedge clk);
    if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
    if (data_valid) begin
      if (exp_data.size() == 0) check("dv_unexp", 32'(data_valid), 32'd0);
      else                      check("data", 32'(data_out), 32'(exp_data.pop_front()));
    end
    if (pkt_done) begin
      if (exp_pkt.size() == 0) check("pd_unexp", 32'(pkt_done), 32'd0);
      else begin
        x = exp_pkt.pop_front();
        check("pkt_err", 32'(pkt_err), 32'(x.err));
        if (x.tp) begin
          check("pkt_type", 32'(pkt_type), 32'(x.t));
          check("pid", 32'(pid), 32'(x.p));
        end
        if (x.ae) begin
          check("addr", 32'(addr), 32'(x.a));
          check("endp", 32'(endp), 32'(x.e));
        end
        check("data_left", 32'(exp_data.size()), 32'd0);
        exp_data.delete();
      end
    end
    refresh();
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_pkt.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    check("timeout", 32'(exp_pkt.size()), 32'd0);
    exp_pkt.delete();
    exp_data.delete();
  endtask

  function automatic logic [15:0] crc16_tx();
    logic [15:0] c = 16'hFFFF;
    logic [15:0] r;
    logic        fb;
    foreach (pl[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = pl[k][i] ^ c[15];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    for (int i = 0; i < 8; i++) begin
      r[i]     = ~c[15-i];
      r[8 + i] = ~c[7-i];
    end
    return r;
  endfunction

  function automatic logic [4:0] crc5_tx(input logic [10:0] d);
    logic [4:0] c = 5'h1F;
    logic [4:0] r;
    logic       fb;
    for (int i = 0; i < 11; i++) begin
      fb = d[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    for (int i = 0; i < 5; i++) r[i] = ~c[4-i];
    return r;
  endfunction

  task automatic send_data(input logic [7:0] pidb, input logic [15:0] crcb, input logic [2:0] err);
    expect_pkt(2'd1, pidb[3:0], 7'd0, 4'd0, err, 1'b1, 1'b0);
    push(pidb);
    foreach (pl[i]) begin
      push(pl[i]);
      if (i < 64) exp_data.push_back(pl[i]);
    end
    push(crcb[7:0]);
    push(crcb[15:8]);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_r_enable"}, 32'(r_enable), 32'd0);
    check({pfx, "_data_out"}, 32'(data_out), 32'd0);
    check({pfx, "_data_valid"}, 32'(data_valid), 32'd0);
    check({pfx, "_pkt_done"}, 32'(pkt_done), 32'd0);
    check({pfx, "_pkt_type"}, 32'(pkt_type), 32'd0);
    check({pfx, "_pid"}, 32'(pid), 32'd0);
    check({pfx, "_addr"}, 32'(addr), 32'd0);
    check({pfx, "_endp"}, 32'(endp), 32'd0);
    check({pfx, "_pkt_err"}, 32'(pkt_err), 32'd0);
  endtask

  initial begin
    int         c0;
    logic [6:0] ta;
    logic [3:0] te;
    logic [4:0] tc;

    #2;
    check_outputs_zero("rst");
    tick();
    tick();
    rst = 1'b0;

    c0 = ren_cnt;
    repeat (20) tick();
    check("ren_idle", 32'(ren_cnt - c0), 32'd0);

    // SETUP token; EOPK held off by rcving until the expectation is posted
    rcving = 1'b1;
    push(8'h2D); push(8'h00); push(8'h10);
    repeat (8) tick();
    expect_pkt(2'd0, 4'hD, 7'd0, 4'd0, 3'd0, 1'b1, 1'b1);
    rcving = 1'b0;
    wait_done();

    expect_pkt(2'd0, 4'hD, 7'd0, 4'd2, 3'd2, 1'b1, 1'b1);
    push(8'h2D); push(8'h00); push(8'h11);
    wait_done();

    expect_pkt(2'd1, 4'h3, 7'd0, 4'd0, 3'd0, 1'b1, 1'b0);
    push(8'hC3); push(8'h00); push(8'h00);
    wait_done();

    pl.delete();
    pl.push_back(8'h80); pl.push_back(8'h06); pl.push_back(8'h00); pl.push_back(8'h01);
    pl.push_back(8'h00); pl.push_back(8'h00); pl.push_back(8'h40); pl.push_back(8'h00);
    send_data(8'hC3, 16'h94DD, 3'd0);
    wait_done();
    send_data(8'hC3, 16'h95DD, 3'd2);
    wait_done();

    pl.delete();
    for (int i = 0; i < 5; i++) pl.push_back(8'($urandom_range(0, 255)));
    send_data(8'h4B, crc16_tx(), 3'd0);
    wait_done();

    pl.delete();
    for (int i = 0; i < 67; i++) pl.push_back(8'(i * 7 + 1));
    send_data(8'hC3, 16'h0000, 3'd3);
    wait_done();

    expect_pkt(2'd2, 4'h2, 7'd0, 4'd0, 3'd0, 1'b1, 1'b0);
    push(8'hD2);
    wait_done();

    expect_pkt(2'd3, 4'h3, 7'd0, 4'd0, 3'd1, 1'b0, 1'b0);
    push(8'hD3); push(8'hAA); push(8'hBB); push(8'hCC);
    wait_done();
    check("drained", 32'(fifo.size()), 32'd0);

    expect_pkt(2'd0, 4'hD, 7'd0, 4'd0, 3'd3, 1'b1, 1'b0);
    push(8'h2D); push(8'h00);
    wait_done();

    expect_pkt(2'd1, 4'h3, 7'd0, 4'd0, 3'd4, 1'b1, 1'b0);
    push(8'hC3);
    for (int i = 0; i < 12; i++) push(8'(i + 16));
    repeat (3) tick();
    r_error = 1'b1;
    tick();
    r_error = 1'b0;
    wait_done();
    check("rx_drained", 32'(fifo.size()), 32'd0);

    // back-to-back: the token is queued on the cycle pkt_done of the ACK is seen
    expect_pkt(2'd2, 4'h2, 7'd0, 4'd0, 3'd0, 1'b1, 1'b0);
    push(8'hD2);
    wait_done();
    ta = 7'h3A;
    te = 4'h9;
    tc = crc5_tx({te, ta});
    expect_pkt(2'd0, 4'h9, ta, te, 3'd0, 1'b1, 1'b1);
    push(8'h69); push({te[0], ta}); push({tc, te[3:1]});
    wait_done();

    push(8'hC3);
    for (int i = 0; i < 6; i++) push(8'(i + 32));
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    fifo.delete();
    refresh();
    tick();
    rst = 1'b0;
    repeat (5) tick();

    check("ren_when_empty", 32'(ren_bad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
